clk_edge_detector: RTL and testbench
====================================

// Module: clk_edge_detector
// PURPOSE
//   Synchronous edge detector: samples WIDTH single-bit inputs on clk through an optional
//   synchronizer chain and emits one-cycle registered pulses on rising, falling and either
//   edge, plus a mode-selected primary pulse. Used by cell/control logic (e.g. TCell) as
//   the single "act now" strobe, so level-sensitive logic fires exactly once per event.
// PARAMETERS
//   WIDTH        1   number of independent input bits (1..32)
//   SYNC_STAGES  2   synchronizer flops before detection (0..4; 0 = input sampled directly)
//   MODE         0   primary edge_out select: 0 rising, 1 falling, 2 both
// PORTS
//   clk       in   1      system clock, all state on posedge
//   reset     in   1      asynchronous, active-high reset
//   sig_in    in   WIDTH  monitored signals (may be asynchronous to clk when SYNC_STAGES>0)
//   rise      out  WIDTH  1-cycle pulse per bit on 0->1
//   fall      out  WIDTH  1-cycle pulse per bit on 1->0
//   any_edge  out  WIDTH  rise | fall
//   edge_out  out  WIDTH  rise, fall or any_edge per MODE
//   ready     out  1      1 once post-reset blanking window has elapsed
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - Reset (async assert, sync-to-clk release): sync chain, history register, blanking
//     counter and all outputs -> 0; ready = 0.
//   - Pipeline per bit: s[0] <= sig_in; s[i] <= s[i-1]; d = s[SYNC_STAGES-1] (d = sig_in
//     when SYNC_STAGES=0); prev <= d every edge.
//   - rise <= d & ~prev; fall <= ~d & prev; any_edge <= d ^ prev; all registered.
//   - Latency: sig_in change set up before posedge k -> pulse high from edge k+SYNC_STAGES
//     to edge k+SYNC_STAGES+1 (exactly one cycle).
//   - Blanking: first SYNC_STAGES+1 posedges after reset release have all pulse outputs
//     forced 0 (prev still updates); ready rises at that edge. No spurious edge for inputs
//     already high at reset release.
//   - Level held: no further pulses. Toggle every cycle: pulse every cycle (rise/fall
//     alternate, any_edge constant 1). Bits fully independent.
//   - rise and fall never both 1 on the same bit; edge_out is pure function of MODE.
//   - Glitch shorter than one clk period may be missed; not an error.
//   - Reset mid-operation: pulse in flight is dropped immediately (async); blanking restarts.
//   - Invalid parameter values (WIDTH<1, SYNC_STAGES>4, MODE>2) must fail elaboration.
// TESTING
//   1 Reset: reset=1 with sig_in toggling -> all outputs 0, ready=0 throughout.
//   2 Defaults, sig_in=1 held through reset release -> ready=1 after 3 edges, rise never
//     pulses.
//   3 Defaults, ready=1, sig_in 0->1 before edge k -> rise=edge_out=any_edge=1 for exactly
//     the cycle after edge k+2, then 0.
//   4 MODE=1, sig_in 1->0 -> fall=edge_out=1 one cycle; 0->1 -> rise=1, edge_out stays 0.
//   5 WIDTH=4, SYNC_STAGES=0, sig_in 4'b0000->4'b1010 -> rise=4'b1010 one cycle after
//     edge k; then 4'b0011 -> rise=4'b0001, fall=4'b1000.
//   6 Reset asserted the same cycle a rise pulse is high -> outputs 0 immediately, no pulse
//     after release.

Source files
------------

// File: rtl/clk_edge_detector.sv
// rtl/clk_edge_detector.sv - per-bit rise/fall/any-edge pulse generator with optional input synchronizer
module clk_edge_detector #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] any_edge,
  output logic [WIDTH-1:0] edge_out,
  output logic             ready
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("clk_edge_detector: WIDTH must be in 1..32");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("clk_edge_detector: SYNC_STAGES must be in 0..4");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("clk_edge_detector: MODE must be 0, 1 or 2");
  end

  localparam int CNT_W = 3;

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] blank_cnt;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign d = sig_in;
  end else begin : g_sync
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= sig_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign d = sync_q[SYNC_STAGES-1];
  end

  // prev keeps tracking d while blanked, so a level already high at release never pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev      <= '0;
      rise      <= '0;
      fall      <= '0;
      any_edge  <= '0;
      blank_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      prev <= d;
      if (ready) begin
        rise     <= d & ~prev;
        fall     <= ~d & prev;
        any_edge <= d ^ prev;
      end else begin
        rise      <= '0;
        fall      <= '0;
        any_edge  <= '0;
        blank_cnt <= blank_cnt + 1'b1;
        if (blank_cnt == CNT_W'(SYNC_STAGES)) ready <= 1'b1;
      end
    end
  end

  if (MODE == 0) begin : g_mode_rise
    assign edge_out = rise;
  end else if (MODE == 1) begin : g_mode_fall
    assign edge_out = fall;
  end else begin : g_mode_any
    assign edge_out = any_edge;
  end

endmodule

// File: tb/tb_clk_edge_detector.sv
// tb/tb_clk_edge_detector.sv - directed checks of clk_edge_detector in three configurations
module tb_clk_edge_detector;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       a     = 1'b0;
  logic       b     = 1'b0;
  logic [3:0] c     = 4'b0000;

  logic       r0, f0, x0, e0, rdy0;
  logic       r1, f1, x1, e1, rdy1;
  logic [3:0] r2, f2, x2, e2;
  logic       rdy2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_edge_detector #(.WIDTH(1), .SYNC_STAGES(2), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .sig_in(a),
    .rise(r0), .fall(f0), .any_edge(x0), .edge_out(e0), .ready(rdy0)
  );

  clk_edge_detector #(.WIDTH(1), .SYNC_STAGES(2), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .sig_in(b),
    .rise(r1), .fall(f1), .any_edge(x1), .edge_out(e1), .ready(rdy1)
  );

  clk_edge_detector #(.WIDTH(4), .SYNC_STAGES(0), .MODE(2)) u2 (
    .clk(clk), .reset(reset), .sig_in(c),
    .rise(r2), .fall(f2), .any_edge(x2), .edge_out(e2), .ready(rdy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      a = ~a; b = ~b; c = ~c;
      tick();
      chk("rst_u0", {r0, f0, x0, e0, rdy0}, 32'h0);
      chk("rst_u1", {r1, f1, x1, e1, rdy1}, 32'h0);
      chk("rst_u2", {r2, f2, x2, e2, rdy2}, 32'h0);
    end
    a = 1'b1; b = 1'b1; c = 4'b0000;
    tick();
    reset = 1'b0;

    tick(); // E1
    chk("e1_rdy0", rdy0, 32'h0);
    chk("e1_rdy2", rdy2, 32'h1);
    chk("e1_u0", {r0, f0, x0, e0}, 32'h0);
    tick(); // E2
    chk("e2_rdy0", rdy0, 32'h0);
    tick(); // E3
    chk("e3_rdy0", rdy0, 32'h1);
    chk("e3_u0", {r0, f0, x0, e0}, 32'h0);
    chk("e3_u1", {r1, f1, x1, e1, rdy1}, 32'h1);
    tick(); // E4
    chk("e4_u0", {r0, f0, x0, e0}, 32'h0);
    chk("e4_u2", {r2, f2, x2, e2}, 32'h0);

    a = 1'b0; b = 1'b0;
    tick(); // E5
    tick(); // E6
    chk("e6_u0", {r0, f0, x0, e0}, 32'h0);
    tick(); // E7
    chk("e7_fall_u0", {r0, f0, x0, e0}, 32'b0110);
    chk("e7_fall_u1", {r1, f1, x1, e1}, 32'b0111);
    tick(); // E8
    chk("e8_u0", {r0, f0, x0, e0}, 32'h0);
    chk("e8_u1", {r1, f1, x1, e1}, 32'h0);

    a = 1'b1; b = 1'b1; c = 4'b1010;
    tick(); // E9
    chk("e9_u2", {r2, f2, x2, e2}, {16'h0, 4'b1010, 4'b0000, 4'b1010, 4'b1010});
    chk("e9_u0", {r0, f0, x0, e0}, 32'h0);
    c = 4'b0011;
    tick(); // E10
    chk("e10_u2", {r2, f2, x2, e2}, {16'h0, 4'b0001, 4'b1000, 4'b1001, 4'b1001});
    tick(); // E11
    chk("e11_rise_u0", {r0, f0, x0, e0}, 32'b1011);
    chk("e11_rise_u1", {r1, f1, x1, e1}, 32'b1010);
    chk("e11_u2", {r2, f2, x2, e2}, 32'h0);
    tick(); // E12
    chk("e12_u0", {r0, f0, x0, e0}, 32'h0);
    chk("e12_u1", {r1, f1, x1, e1}, 32'h0);

    c = 4'b0111;
    tick(); // E13
    chk("e13_u2", {r2, f2, x2, e2}, {16'h0, 4'b0100, 4'b0000, 4'b0100, 4'b0100});
    #2 reset = 1'b1;
    #1;
    chk("rst_async_u2", {r2, f2, x2, e2, rdy2}, 32'h0);
    chk("rst_async_u0", {r0, f0, x0, e0, rdy0}, 32'h0);
    tick(); // E14
    chk("e14_u2", {r2, f2, x2, e2, rdy2}, 32'h0);
    #1 reset = 1'b0;
    tick(); // E15
    chk("e15_u2", {r2, f2, x2, e2, rdy2}, 32'h1);
    chk("e15_rdy0", rdy0, 32'h0);
    tick(); // E16
    chk("e16_u2", {r2, f2, x2, e2, rdy2}, 32'h1);
    tick(); // E17
    chk("e17_u0", {r0, f0, x0, e0, rdy0}, 32'h1);

    // toggling bit 0 every cycle pulses every cycle, rise/fall alternating
    for (int i = 0; i < 4; i++) begin
      c[0] = ~c[0];
      tick();
      if (c[0])
        chk("toggle_u2", {r2, f2, x2, e2}, {16'h0, 4'b0001, 4'b0000, 4'b0001, 4'b0001});
      else
        chk("toggle_u2", {r2, f2, x2, e2}, {16'h0, 4'b0000, 4'b0001, 4'b0001, 4'b0001});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
